// File: rtl/aurora_link_ctrl_pkg.sv
// Shared types and helpers for the Aurora lane-pair bring-up sequencer.
package aurora_link_ctrl_pkg;

  localparam int RETRAIN_W  = 16;
  localparam int SOFT_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET      = 3'd1,
    ST_WAIT_UP    = 3'd2,
    ST_BIST_RUN   = 3'd3,
    ST_BIST_DRAIN = 3'd4,
    ST_ACTIVE     = 3'd5
  } link_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/aurora_link_ctrl.sv
// Link bring-up / supervision sequencer: PHY reset, channel-up wait,
// optional PRBS BIST, then user traffic with hard/soft error supervision.
module aurora_link_ctrl
  import aurora_link_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 256,
  parameter int unsigned UP_TIMEOUT   = 65536,
  parameter int unsigned BIST_CYCLES  = 512,
  parameter int unsigned DRAIN_CYCLES = 256,
  parameter int unsigned SOFT_WINDOW  = 4096,
  parameter int unsigned SOFT_THRESH  = 16,
  parameter logic [5:0]  BIST_RATE    = 6'd60
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 bist_en,
  input  logic                 channel_up,
  input  logic                 hard_err,
  input  logic                 soft_err,
  input  logic                 bist_checker_locked,
  input  logic [47:0]          bist_checker_samps,
  input  logic [47:0]          bist_checker_errors,
  output logic                 phy_reset,
  output logic                 bist_gen_en,
  output logic                 bist_checker_en,
  output logic [5:0]           bist_gen_rate,
  output logic                 traffic_en,
  output logic                 link_up,
  output logic                 bist_fail,
  output logic [RETRAIN_W-1:0] retrain_cnt,
  output logic [2:0]           state
);

  localparam logic [SOFT_CNT_W-1:0] SOFT_THRESH_V = SOFT_CNT_W'(SOFT_THRESH);

  link_state_t            state_q, state_d;
  logic [31:0]            timer_q, timer_d;
  logic                   lock_seen_q, lock_seen_d;
  logic                   bist_pass_q, bist_pass_d;
  logic                   bist_fail_q, bist_fail_d;
  logic [RETRAIN_W-1:0]   retrain_cnt_q, retrain_cnt_d;
  logic [SOFT_CNT_W-1:0]  soft_cnt_q, soft_cnt_d;
  logic [SOFT_CNT_W-1:0]  soft_next;
  logic                   retrain_req;
  logic                   phy_reset_q, phy_reset_d;
  logic                   bist_gen_en_q, bist_gen_en_d;
  logic                   bist_checker_en_q, bist_checker_en_d;
  logic                   traffic_en_q, traffic_en_d;

  // Next-state, shared timer, BIST verdict, error counters and output decode.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + 32'd1;
    lock_seen_d   = lock_seen_q;
    bist_pass_d   = bist_pass_q;
    bist_fail_d   = bist_fail_q;
    retrain_cnt_d = retrain_cnt_q;
    soft_cnt_d    = '0;
    retrain_req   = 1'b0;

    // Timer value 0 marks the first cycle of a soft-error window; a pulse
    // landing there is the first error of the new window.
    if (timer_q == 32'd0) begin
      soft_next = {{(SOFT_CNT_W-1){1'b0}}, soft_err};
    end else if (soft_err) begin
      soft_next = sat_inc(soft_cnt_q);
    end else begin
      soft_next = soft_cnt_q;
    end

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_RESET;
          bist_fail_d = 1'b0;
        end
        ST_RESET: begin
          if (timer_q == RESET_CYCLES - 1) state_d = ST_WAIT_UP;
        end
        ST_WAIT_UP: begin
          if (channel_up) begin
            state_d = bist_en ? ST_BIST_RUN : ST_ACTIVE;
          end else if (timer_q == UP_TIMEOUT - 1) begin
            state_d     = ST_RESET;
            retrain_req = 1'b1;
          end
        end
        ST_BIST_RUN: begin
          if (!channel_up) begin
            state_d     = ST_RESET;
            bist_fail_d = 1'b1;
            retrain_req = 1'b1;
          end else if (!lock_seen_q) begin
            // Lock restarts the timer so the measurement period is post-lock.
            if (bist_checker_locked) begin
              lock_seen_d = 1'b1;
              timer_d     = 32'd0;
            end else if (timer_q == UP_TIMEOUT - 1) begin
              state_d     = ST_RESET;
              bist_fail_d = 1'b1;
              retrain_req = 1'b1;
            end
          end else if (timer_q == BIST_CYCLES - 1) begin
            state_d     = ST_BIST_DRAIN;
            bist_pass_d = (bist_checker_samps != 48'd0) && (bist_checker_errors == 48'd0);
            if (!bist_pass_d) bist_fail_d = 1'b1;
          end
        end
        ST_BIST_DRAIN: begin
          if (!channel_up) begin
            state_d     = ST_RESET;
            bist_fail_d = 1'b1;
            retrain_req = 1'b1;
          end else if (timer_q == DRAIN_CYCLES - 1) begin
            if (bist_pass_q) begin
              state_d = ST_ACTIVE;
            end else begin
              state_d     = ST_RESET;
              retrain_req = 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          soft_cnt_d = soft_next;
          if (hard_err || !channel_up) begin
            state_d     = ST_RESET;
            retrain_req = 1'b1;
          end else if (soft_next >= SOFT_THRESH_V) begin
            state_d     = ST_RESET;
            retrain_req = 1'b1;
          end else if (timer_q == SOFT_WINDOW - 1) begin
            timer_d = 32'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Every state entry starts with a fresh timer and no lock history.
    if (state_d != state_q || state_q == ST_IDLE) begin
      timer_d     = 32'd0;
      lock_seen_d = 1'b0;
      soft_cnt_d  = '0;
    end

    if (retrain_req) retrain_cnt_d = sat_inc(retrain_cnt_q);

    phy_reset_d       = (state_d == ST_IDLE) || (state_d == ST_RESET);
    bist_gen_en_d     = (state_d == ST_BIST_RUN);
    bist_checker_en_d = (state_d == ST_BIST_RUN) || (state_d == ST_BIST_DRAIN);
    traffic_en_d      = (state_d == ST_ACTIVE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      timer_q           <= 32'd0;
      lock_seen_q       <= 1'b0;
      bist_pass_q       <= 1'b0;
      bist_fail_q       <= 1'b0;
      retrain_cnt_q     <= '0;
      soft_cnt_q        <= '0;
      phy_reset_q       <= 1'b1;
      bist_gen_en_q     <= 1'b0;
      bist_checker_en_q <= 1'b0;
      traffic_en_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      lock_seen_q       <= lock_seen_d;
      bist_pass_q       <= bist_pass_d;
      bist_fail_q       <= bist_fail_d;
      retrain_cnt_q     <= retrain_cnt_d;
      soft_cnt_q        <= soft_cnt_d;
      phy_reset_q       <= phy_reset_d;
      bist_gen_en_q     <= bist_gen_en_d;
      bist_checker_en_q <= bist_checker_en_d;
      traffic_en_q      <= traffic_en_d;
    end
  end

  assign phy_reset       = phy_reset_q;
  assign bist_gen_en     = bist_gen_en_q;
  assign bist_checker_en = bist_checker_en_q;
  assign bist_gen_rate   = BIST_RATE;
  assign traffic_en      = traffic_en_q;
  assign link_up         = traffic_en_q;
  assign bist_fail       = bist_fail_q;
  assign retrain_cnt     = retrain_cnt_q;
  assign state           = state_q;

endmodule

// File: tb/tb_aurora_link_ctrl.sv
// Directed-plus-random bench for aurora_link_ctrl with a cycle-count model.
module tb_aurora_link_ctrl;

  localparam int unsigned RC = 16;
  localparam int unsigned UT = 1000;
  localparam int unsigned BC = 512;
  localparam int unsigned DC = 256;
  localparam int unsigned SW = 4096;
  localparam int unsigned TH = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_ACT   = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        bist_en = 1'b0;
  logic        channel_up = 1'b0;
  logic        hard_err = 1'b0;
  logic        soft_err = 1'b0;
  logic        bist_checker_locked = 1'b0;
  logic [47:0] bist_checker_samps = '0;
  logic [47:0] bist_checker_errors = '0;
  logic        phy_reset, bist_gen_en, bist_checker_en, traffic_en, link_up, bist_fail;
  logic [5:0]  bist_gen_rate;
  logic [15:0] retrain_cnt;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;
  int exp_retrain = 0;
  bit pulse_map [0:3*SW-1];

  aurora_link_ctrl #(
    .RESET_CYCLES(RC), .UP_TIMEOUT(UT), .BIST_CYCLES(BC), .DRAIN_CYCLES(DC),
    .SOFT_WINDOW(SW), .SOFT_THRESH(TH), .BIST_RATE(6'd60)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bist_en(bist_en),
    .channel_up(channel_up), .hard_err(hard_err), .soft_err(soft_err),
    .bist_checker_locked(bist_checker_locked),
    .bist_checker_samps(bist_checker_samps),
    .bist_checker_errors(bist_checker_errors),
    .phy_reset(phy_reset), .bist_gen_en(bist_gen_en),
    .bist_checker_en(bist_checker_en), .bist_gen_rate(bist_gen_rate),
    .traffic_en(traffic_en), .link_up(link_up), .bist_fail(bist_fail),
    .retrain_cnt(retrain_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
    $display("chk %-14s got=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      step();
      n++;
    end
    chk(tag, state, s);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"}, state, S_IDLE);
    chk({pfx, "_phyrst"}, phy_reset, 1'b1);
    chk({pfx, "_fail"}, bist_fail, 1'b0);
    chk({pfx, "_retr"}, retrain_cnt, 16'd0);
    chk({pfx, "_gen"}, bist_gen_en, 1'b0);
    chk({pfx, "_chk"}, bist_checker_en, 1'b0);
    chk({pfx, "_traf"}, traffic_en, 1'b0);
    chk({pfx, "_lup"}, link_up, 1'b0);
  endtask

  initial begin
    int n, m, d, k, cnt, win, cur_win;
    bit trig;
    logic pass_exp;

    // Soft-error schedule: 15 pulses in window 0 (last one on its final
    // cycle), 15 in window 1 (first on its first cycle), 16 in window 2.
    for (int i = 0; i < 3*SW; i++) pulse_map[i] = 1'b0;
    for (int j = 0; j < 14; j++) pulse_map[j*250 + int'($urandom_range(0, 199))] = 1'b1;
    pulse_map[SW-1] = 1'b1;
    pulse_map[SW] = 1'b1;
    for (int j = 0; j < 14; j++) pulse_map[SW + 300 + j*250 + int'($urandom_range(0, 199))] = 1'b1;
    pulse_map[2*SW] = 1'b1;
    for (int j = 0; j < 15; j++) pulse_map[2*SW + 300 + j*250 + int'($urandom_range(0, 199))] = 1'b1;

    // Reset values
    repeat (3) step();
    chk_reset_vals("rst");
    chk("rst_rate", bist_gen_rate, 6'd60);
    rst_n = 1'b1;
    step();
    chk("idle_hold", state, S_IDLE);

    // Bring-up without BIST
    enable = 1'b1;
    step();
    chk("enter_reset", state, S_RESET);
    n = 0;
    while (phy_reset && n < int'(RC) + 10) begin n++; step(); end
    chk("reset_len", n, RC);
    chk("wait_state", state, S_WAIT);
    d = int'($urandom_range(50, 150));
    repeat (d) step();
    chk("wait_lup0", link_up, 1'b0);
    channel_up = 1'b1;
    step();
    chk("up_lup", link_up, 1'b1);
    chk("up_traf", traffic_en, 1'b1);
    chk("up_state", state, S_ACT);
    chk("up_retr", retrain_cnt, exp_retrain);

    // Soft errors: model counts pulses per window since ACTIVE entry
    cnt = 0; cur_win = 0; trig = 1'b0;
    for (k = 0; k < int'(3*SW) && !trig; k++) begin
      soft_err = pulse_map[k];
      step();
      win = k / int'(SW);
      if (win != cur_win) begin cur_win = win; cnt = 0; end
      cnt += int'(pulse_map[k]);
      if (cnt >= int'(TH)) begin
        trig = 1'b1;
        chk("soft_trip", state, S_RESET);
      end else if (pulse_map[k]) begin
        if (state !== S_ACT) chk("soft_hold", state, S_ACT);
      end
    end
    soft_err = 1'b0;
    exp_retrain++;
    chk("soft_trig", trig, 1'b1);
    chk("soft_win", cur_win, 2);
    chk("soft_retr", retrain_cnt, exp_retrain);

    // Hard error drops traffic on the next cycle
    wait_state(S_ACT, int'(RC) + 10, "reup_soft");
    repeat (int'($urandom_range(1, 30))) step();
    hard_err = 1'b1;
    step();
    hard_err = 1'b0;
    channel_up = 1'b0;
    exp_retrain++;
    chk("hard_traf", traffic_en, 1'b0);
    chk("hard_lup", link_up, 1'b0);
    chk("hard_state", state, S_RESET);
    chk("hard_retr", retrain_cnt, exp_retrain);

    // Channel-up timeout, three attempts
    for (int a = 0; a < 3; a++) begin
      wait_state(S_WAIT, int'(RC) + 10, "to_wait");
      n = 0;
      while (!phy_reset && n < int'(UT) + 10) begin n++; step(); end
      exp_retrain++;
      chk("to_len", n, UT);
      chk("to_state", state, S_RESET);
      chk("to_retr", retrain_cnt, exp_retrain);
    end

    // BIST pass
    bist_en = 1'b1;
    wait_state(S_WAIT, int'(RC) + 10, "bp_wait");
    repeat (int'($urandom_range(5, 50))) step();
    channel_up = 1'b1;
    step();
    chk("bp_run", state, S_RUN);
    chk("bp_gen", bist_gen_en, 1'b1);
    chk("bp_chk", bist_checker_en, 1'b1);
    repeat (int'($urandom_range(5, 40))) step();
    chk("bp_prelock", bist_gen_en, 1'b1);
    bist_checker_samps = 48'($urandom_range(1, 100000));
    bist_checker_errors = '0;
    bist_checker_locked = 1'b1;
    step();
    n = 0;
    while (bist_gen_en && n < int'(BC) + 10) begin n++; step(); end
    chk("bp_genlen", n, BC);
    chk("bp_drain", state, S_DRAIN);
    m = 0;
    while (bist_checker_en && m < int'(DC) + 10) begin m++; step(); end
    chk("bp_drainlen", m, DC);
    chk("bp_act", state, S_ACT);
    chk("bp_fail", bist_fail, 1'b0);
    chk("bp_lup", link_up, 1'b1);

    // BIST fail (either errors seen or no samples), then a passing retry
    if ($urandom_range(0, 1) == 1) begin
      bist_checker_errors = 48'($urandom_range(1, 255));
      bist_checker_samps = 48'($urandom_range(1, 100000));
    end else begin
      bist_checker_errors = '0;
      bist_checker_samps = '0;
    end
    pass_exp = (bist_checker_samps != 48'd0) && (bist_checker_errors == 48'd0);
    bist_checker_locked = 1'b0;
    hard_err = 1'b1;
    step();
    hard_err = 1'b0;
    exp_retrain++;
    chk("bf_retr0", retrain_cnt, exp_retrain);
    wait_state(S_RUN, int'(RC) + 10, "bf_run");
    repeat (int'($urandom_range(1, 20))) step();
    bist_checker_locked = 1'b1;
    wait_state(S_DRAIN, int'(BC) + 40, "bf_drain");
    chk("bf_flag", bist_fail, !pass_exp);
    wait_state(S_RESET, int'(DC) + 10, "bf_reset");
    exp_retrain++;
    chk("bf_retr", retrain_cnt, exp_retrain);
    bist_checker_errors = '0;
    bist_checker_samps = 48'd300;
    wait_state(S_ACT, int'(RC + BC + DC) + 30, "bf_retry");
    chk("bf_sticky", bist_fail, 1'b1);
    chk("bf_lup", link_up, 1'b1);

    // Disable during BIST_RUN
    bist_checker_locked = 1'b0;
    hard_err = 1'b1;
    step();
    hard_err = 1'b0;
    exp_retrain++;
    wait_state(S_RUN, int'(RC) + 10, "dis_run");
    repeat (int'($urandom_range(1, 50))) step();
    enable = 1'b0;
    step();
    chk("dis_state", state, S_IDLE);
    chk("dis_gen", bist_gen_en, 1'b0);
    chk("dis_chk", bist_checker_en, 1'b0);
    chk("dis_phyrst", phy_reset, 1'b1);
    chk("dis_retr", retrain_cnt, exp_retrain);
    enable = 1'b1;
    bist_en = 1'b0;
    step();
    chk("ren_state", state, S_RESET);
    chk("ren_failclr", bist_fail, 1'b0);

    // Channel loss in ACTIVE
    wait_state(S_ACT, int'(RC) + 10, "cl_act");
    channel_up = 1'b0;
    step();
    exp_retrain++;
    chk("cl_state", state, S_RESET);
    chk("cl_retr", retrain_cnt, exp_retrain);
    channel_up = 1'b1;
    wait_state(S_ACT, int'(RC) + 10, "cl_reup");

    // enable=0 beats hard_err in the same cycle
    enable = 1'b0;
    hard_err = 1'b1;
    step();
    hard_err = 1'b0;
    chk("pri_state", state, S_IDLE);
    chk("pri_retr", retrain_cnt, exp_retrain);
    enable = 1'b1;
    wait_state(S_ACT, int'(RC) + 12, "pri_reup");

    // Reset in ACTIVE
    rst_n = 1'b0;
    step();
    chk_reset_vals("mrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aurora_link_ctrl.md
# aurora_link_ctrl

Link bring-up and supervision sequencer for one Aurora 64b/66b lane pair, sitting between the regport/control logic and the `aurora_phy_x1` + `aurora_axis_mac` pair. It holds the PHY in reset, waits for `channel_up`, optionally runs a PRBS BIST through the MAC's BIST generator/checker, and only then enables user traffic. While the link is active it monitors hard and soft errors, forcing a retrain when required and counting retrains.

## Interface
- `RESET_CYCLES`, 256: cycles `phy_reset` is held per attempt (min 1).
- `UP_TIMEOUT`, 65536: max cycles waiting for `channel_up` or BIST lock.
- `BIST_CYCLES`, 512: cycles counted after checker lock.
- `DRAIN_CYCLES`, 256: cycles between gen-off and checker-off.
- `SOFT_WINDOW`, 4096: soft-error observation window, in cycles.
- `SOFT_THRESH`, 16: soft errors within one window that force a retrain.
- `BIST_RATE`, 6'd60: value driven on `bist_gen_rate`.
- `clk` in 1: single clock (Aurora user_clk domain).
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: 0 returns to IDLE from any state.
- `bist_en` in 1: run BIST before ACTIVE; sampled on exit from WAIT_UP.
- `channel_up` in 1: from PHY.
- `hard_err` in 1: from PHY.
- `soft_err` in 1: from PHY, one pulse per error.
- `bist_checker_locked` in 1: from MAC.
- `bist_checker_samps` in 48: from MAC.
- `bist_checker_errors` in 48: from MAC.
- `phy_reset` out 1: PHY/MAC reset request.
- `bist_gen_en` out 1: MAC BIST generator enable.
- `bist_checker_en` out 1: MAC BIST checker enable.
- `bist_gen_rate` out 6: constant `BIST_RATE`.
- `traffic_en` out 1: gates user AXIS valid/ready.
- `link_up` out 1: equals `traffic_en`.
- `bist_fail` out 1: sticky; cleared on entry to RESET from IDLE.
- `retrain_cnt` out 16: number of retrains; saturates at 0xFFFF.
- `state` out 3: encoded current state.

## Operation
- States (encodings 0–5): IDLE, RESET, WAIT_UP, BIST_RUN, BIST_DRAIN, ACTIVE.
- **IDLE:** `phy_reset`=1, all other enables 0. Goes to RESET when `enable`=1; this transition clears `bist_fail`.
- **RESET:** `phy_reset`=1 for exactly `RESET_CYCLES` cycles, then WAIT_UP.
- **WAIT_UP:**
  - `phy_reset`=0.
  - When `channel_up`=1, go to BIST_RUN if `bist_en`=1, otherwise ACTIVE.
  - Timer reaches `UP_TIMEOUT`: go to RESET and increment `retrain_cnt`.
- **BIST_RUN:**
  - `bist_gen_en`=1 and `bist_checker_en`=1.
  - Wait for `bist_checker_locked`. If lock is not seen within `UP_TIMEOUT`: set `bist_fail`, go to RESET, increment `retrain_cnt`.
  - After lock, count `BIST_CYCLES`, then evaluate. Pass requires `bist_checker_samps`>0 and `bist_checker_errors`==0.
  - Pass or fail, go to BIST_DRAIN. On fail, also set `bist_fail`.
- **BIST_DRAIN:**
  - `bist_gen_en`=0 and `bist_checker_en`=1 for `DRAIN_CYCLES` cycles.
  - Then go to ACTIVE if BIST passed, otherwise go to RESET and increment `retrain_cnt`.
- **ACTIVE:**
  - `traffic_en`=`link_up`=1.
  - `hard_err`=1 or `channel_up`=0: go to RESET, increment `retrain_cnt`.
  - Soft-error counter counts `soft_err` pulses and clears at each `SOFT_WINDOW` boundary. When the count reaches `SOFT_THRESH`, go to RESET and increment `retrain_cnt`.
- Loss of `channel_up` during BIST_RUN or BIST_DRAIN: set `bist_fail`, go to RESET, increment `retrain_cnt`.
- `enable`=0 overrides every other condition and goes to IDLE. This does not increment `retrain_cnt`.
- One cycle with several triggers: priority is `enable`=0, then `hard_err`, then `channel_up` loss, then timeout, then soft threshold.

## Timing
- Reset values:
  - `state`=IDLE, `phy_reset`=1, `bist_fail`=0, `retrain_cnt`=0.
  - All enables and `traffic_en`/`link_up` are 0.
- All outputs are registered and decoded from the current state; latency is one cycle from the triggering input to the output change.
- The single timer reloads to 0 on every state entry.
- `traffic_en` falls in the cycle after `hard_err` is sampled, so at most one beat is accepted after the error.
- The soft-error counter is 16 bits, saturating; the window timer wraps.
- `soft_err` and a window boundary in the same cycle: the counter restarts at 1.

## Structure
- Package `aurora_link_ctrl_pkg`:
  - `link_state_t` enum (3 bits, encodings as listed under Operation).
  - `RETRAIN_W`=16.
- No sub-module is required. The single down/up timer shared by all states is kept inline.

## Test plan
- **Bring-up without BIST:** `bist_en`=0, `channel_up` rises 100 cycles after RESET exits → `link_up`=1 one cycle after `channel_up`; `retrain_cnt`=0.
- **BIST pass:** `bist_en`=1, lock after 20 cycles, samps=300, errors=0 → gen on for 512 post-lock cycles, checker off 256 cycles later, ACTIVE, `bist_fail`=0.
- **BIST fail:** errors=5 at evaluation → `bist_fail`=1, state RESET, `retrain_cnt`=1; the next attempt passing reaches ACTIVE with `bist_fail` still 1.
- **Up timeout:** `channel_up` held 0 with `UP_TIMEOUT`=1000 → `phy_reset` reasserts at cycle 1000 of WAIT_UP; three attempts give `retrain_cnt`=3.
- **ACTIVE errors:** 16 `soft_err` pulses within 4096 cycles → RESET and `retrain_cnt`+1; 15 pulses per window → stays ACTIVE; a `hard_err` pulse → `traffic_en`=0 next cycle.
- **Disable and reset mid-operation:** `enable`=0 in BIST_RUN → IDLE next cycle, gen/checker off, count unchanged; `rst_n`=0 in ACTIVE → every output at its reset value next cycle.
